// File: rtl/mem_if_checker_pkg.sv
// Shared definitions for the req/gnt memory interface checker.
// Violation codes double as flag bit indices: {SPUR,TIMEOUT,DROP,STABLE}.
package mem_if_checker_pkg;

  localparam logic [1:0] CODE_STABLE  = 2'd0;
  localparam logic [1:0] CODE_DROP    = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT = 2'd2;
  localparam logic [1:0] CODE_SPUR    = 2'd3;

  localparam int FLAG_STABLE  = 0;
  localparam int FLAG_DROP    = 1;
  localparam int FLAG_TIMEOUT = 2;
  localparam int FLAG_SPUR    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_if_checker_channel.sv
// One monitored req/gnt channel: FSM, request capture, wait counter, txn counter, sticky flags.
// Detection is registered; with MEM_IF_CHECKER_FORMAL_EN each violation is also asserted.
module mem_if_checker_channel
  import mem_if_checker_pkg::*;
#(
  parameter int AW       = 64,
  parameter int DW       = 64,
  parameter int MAX_WAIT = 16,
  parameter int CW       = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear,
  input  logic            req,
  input  logic [AW-1:0]   addr,
  input  logic            wen,
  input  logic [DW/8-1:0] strb,
  input  logic [DW-1:0]   wdata,
  input  logic            gnt,
  output logic [3:0]      flags,
  output logic [3:0]      events,
  output logic [CW-1:0]   txn_count
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  state_t            state, state_nxt;
  logic [AW-1:0]     cap_addr;
  logic              cap_wen;
  logic [DW/8-1:0]   cap_strb;
  logic [DW-1:0]     cap_wdata;
  logic [WCW-1:0]    wait_ctr;
  logic              to_seen;
  logic              in_wait;
  logic              mismatch;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req && !gnt) state_nxt = WAIT;
      WAIT:    if (!req || gnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes only matter for a held write; reads may leave them floating.
  always_comb begin
    in_wait  = (state == WAIT);
    mismatch = (addr != cap_addr) || (wen != cap_wen) || (wdata != cap_wdata) ||
               (cap_wen && (strb != cap_strb));
    events                = '0;
    events[FLAG_STABLE]   = in_wait && req && mismatch;
    events[FLAG_DROP]     = in_wait && !req;
    events[FLAG_TIMEOUT]  = in_wait && (wait_ctr == WCW'(MAX_WAIT)) && !gnt && !to_seen;
    events[FLAG_SPUR]     = gnt && !req;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cap_addr  <= '0;
      cap_wen   <= 1'b0;
      cap_strb  <= '0;
      cap_wdata <= '0;
      wait_ctr  <= '0;
      to_seen   <= 1'b0;
      flags     <= '0;
      txn_count <= '0;
    end else begin
      if (state == IDLE && req && !gnt) begin
        cap_addr  <= addr;
        cap_wen   <= wen;
        cap_strb  <= strb;
        cap_wdata <= wdata;
        wait_ctr  <= WCW'(1);
      end else if (in_wait && req && !gnt && wait_ctr != WCW'(MAX_WAIT)) begin
        wait_ctr  <= wait_ctr + WCW'(1);
      end
      if (state_nxt == IDLE) to_seen <= 1'b0;
      else                   to_seen <= to_seen | events[FLAG_TIMEOUT];
      // A fresh violation survives a simultaneous clear.
      flags <= (clear ? 4'b0000 : flags) | events;
      if (req && gnt) txn_count <= txn_count + CW'(1);
    end
  end

`ifdef MEM_IF_CHECKER_FORMAL_EN
  always @(posedge clk) begin
    if (resetn) begin
      assume (!(gnt && !req));
      assert (!events[FLAG_STABLE]);
      assert (!events[FLAG_DROP]);
      assert (!events[FLAG_TIMEOUT]);
      assert (!events[FLAG_SPUR]);
    end
  end
`endif

endmodule

// File: rtl/mem_if_checker.sv
// Multi-channel req/gnt protocol checker: per-channel sticky flags, txn counters, first-error capture.
// Optional MEM_IF_CHECKER_FORMAL_EN adds per-violation asserts and gnt-implies-req assumes.
module mem_if_checker
  import mem_if_checker_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int AW       = 64,
  parameter int DW       = 64,
  parameter int MAX_WAIT = 16,
  parameter int CW       = 16
) (
  input  logic                  f_clk,
  input  logic                  g_resetn,
  input  logic                  clear,
  input  logic [NCH-1:0]        ch_req,
  input  logic [NCH*AW-1:0]     ch_addr,
  input  logic [NCH-1:0]        ch_wen,
  input  logic [NCH*DW/8-1:0]   ch_strb,
  input  logic [NCH*DW-1:0]     ch_wdata,
  input  logic [NCH-1:0]        ch_gnt,
  output logic [NCH*4-1:0]      viol_flags,
  output logic                  viol_any,
  output logic                  first_valid,
  output logic [2:0]            first_ch,
  output logic [1:0]            first_code,
  output logic [NCH*CW-1:0]     txn_count
);

  logic [NCH*4-1:0] events;
  logic             hit;
  logic [2:0]       sel_ch;
  logic [1:0]       sel_code;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    mem_if_checker_channel #(
      .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .CW(CW)
    ) u_ch (
      .clk       (f_clk),
      .resetn    (g_resetn),
      .clear     (clear),
      .req       (ch_req[i]),
      .addr      (ch_addr[i*AW +: AW]),
      .wen       (ch_wen[i]),
      .strb      (ch_strb[i*(DW/8) +: DW/8]),
      .wdata     (ch_wdata[i*DW +: DW]),
      .gnt       (ch_gnt[i]),
      .flags     (viol_flags[i*4 +: 4]),
      .events    (events[i*4 +: 4]),
      .txn_count (txn_count[i*CW +: CW])
    );
  end

  assign viol_any = |viol_flags;

  // Scan from highest to lowest so the lowest channel, then lowest code, is written last.
  always_comb begin
    hit      = 1'b0;
    sel_ch   = '0;
    sel_code = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      for (int c = 3; c >= 0; c--) begin
        if (events[i*4 + c]) begin
          hit      = 1'b1;
          sel_ch   = 3'(i);
          sel_code = 2'(c);
        end
      end
    end
  end

  always_ff @(posedge f_clk) begin
    if (!g_resetn) begin
      first_valid <= 1'b0;
      first_ch    <= '0;
      first_code  <= '0;
    end else if (hit && (!first_valid || clear)) begin
      first_valid <= 1'b1;
      first_ch    <= sel_ch;
      first_code  <= sel_code;
    end else if (clear) begin
      first_valid <= 1'b0;
      first_ch    <= '0;
      first_code  <= '0;
    end
  end

endmodule

// File: tb/tb_mem_if_checker.sv
// Directed-vector bench for mem_if_checker with NCH=2, 32-bit bus, MAX_WAIT=4.
module tb_mem_if_checker;

  localparam int NCH = 2, AW = 32, DW = 32, MW = 4, CW = 16;

  logic                f_clk = 1'b0;
  logic                g_resetn;
  logic                clear;
  logic [NCH-1:0]      ch_req, ch_wen, ch_gnt;
  logic [NCH*AW-1:0]   ch_addr;
  logic [NCH*DW/8-1:0] ch_strb;
  logic [NCH*DW-1:0]   ch_wdata;
  logic [NCH*4-1:0]    viol_flags;
  logic                viol_any, first_valid;
  logic [2:0]          first_ch;
  logic [1:0]          first_code;
  logic [NCH*CW-1:0]   txn_count;

  int checks = 0;
  int errors = 0;

  mem_if_checker #(.NCH(NCH), .AW(AW), .DW(DW), .MAX_WAIT(MW), .CW(CW)) dut (
    .f_clk(f_clk), .g_resetn(g_resetn), .clear(clear),
    .ch_req(ch_req), .ch_addr(ch_addr), .ch_wen(ch_wen), .ch_strb(ch_strb),
    .ch_wdata(ch_wdata), .ch_gnt(ch_gnt),
    .viol_flags(viol_flags), .viol_any(viol_any), .first_valid(first_valid),
    .first_ch(first_ch), .first_code(first_code), .txn_count(txn_count)
  );

  always #5 f_clk = ~f_clk;

  task automatic tick();
    @(posedge f_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_first(input string tag, input logic v, input logic [2:0] ch, input logic [1:0] code);
    check({tag, "_valid"}, 64'(first_valid), 64'(v));
    check({tag, "_ch"},    64'(first_ch),    64'(ch));
    check({tag, "_code"},  64'(first_code),  64'(code));
  endtask

  initial begin
    g_resetn = 1'b0; clear = 1'b0;
    ch_req = '0; ch_wen = '0; ch_gnt = '0;
    ch_addr = '0; ch_strb = '0; ch_wdata = '0;
    tick(); tick();
    check("rst_flags", 64'(viol_flags), 64'h0);
    check("rst_any",   64'(viol_any),   64'h0);
    check("rst_txn",   64'(txn_count),  64'h0);
    check_first("rst_first", 1'b0, 3'd0, 2'd0);
    g_resetn = 1'b1;
    tick();

    // Back-to-back accepted transactions on ch0
    ch_req[0] = 1'b1; ch_gnt[0] = 1'b1; ch_addr[31:0] = 32'h100;
    for (int k = 0; k < 5; k++) tick();
    ch_req[0] = 1'b0; ch_gnt[0] = 1'b0;
    check("acc_txn0",  64'(txn_count[15:0]),  64'd5);
    check("acc_txn1",  64'(txn_count[31:16]), 64'd0);
    check("acc_flags", 64'(viol_flags),       64'h0);
    check("acc_first", 64'(first_valid),      64'h0);

    // ch1 address changes while waiting -> STABLE
    ch_req[1] = 1'b1; ch_addr[63:32] = 32'h1000;
    tick();
    check("stb_pre", 64'(viol_flags), 64'h0);
    ch_addr[63:32] = 32'h1008;
    tick();
    check("stb_flag", 64'(viol_flags[4]), 64'h1);
    tick();
    check_first("stb_first", 1'b1, 3'd1, 2'd0);
    ch_gnt[1] = 1'b1;
    tick();
    check("stb_txn1", 64'(txn_count[31:16]), 64'd1);
    ch_req[1] = 1'b0; ch_gnt[1] = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("stb_clr_flags", 64'(viol_flags),  64'h0);
    check("stb_clr_first", 64'(first_valid), 64'h0);

    // ch0 starvation: no flag through wait cycle 4, TIMEOUT after wait cycle 5
    ch_req[0] = 1'b1; ch_addr[31:0] = 32'h2000;
    tick(); check("to_w1", 64'(viol_flags), 64'h0);
    tick(); check("to_w2", 64'(viol_flags), 64'h0);
    tick(); check("to_w3", 64'(viol_flags), 64'h0);
    tick(); check("to_w4", 64'(viol_flags), 64'h0);
    tick(); check("to_w5", 64'(viol_flags), 64'h04);
    check_first("to_first", 1'b1, 3'd0, 2'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("to_w6_clr", 64'(viol_flags), 64'h0);
    tick();
    check("to_once",       64'(viol_flags),  64'h0);
    check("to_once_first", 64'(first_valid), 64'h0);
    ch_gnt[0] = 1'b1;
    tick();
    check("to_txn0", 64'(txn_count[15:0]), 64'd6);
    ch_req[0] = 1'b0; ch_gnt[0] = 1'b0;
    tick();

    // ch0 DROP and ch1 SPUR in the same cycle
    ch_req[0] = 1'b1;
    tick();
    ch_req[0] = 1'b0; ch_gnt[1] = 1'b1;
    tick();
    ch_gnt[1] = 1'b0;
    check("ds_flags", 64'(viol_flags), 64'h82);
    check("ds_any",   64'(viol_any),   64'h1);
    check_first("ds_first", 1'b1, 3'd0, 2'd1);

    // clear coincides with a new ch1 DROP: the new violation wins
    ch_req[1] = 1'b1;
    tick();
    check("cd_hold_ch", 64'(first_ch), 64'd0);
    ch_req[1] = 1'b0; clear = 1'b1;
    tick();
    check("cd_flags", 64'(viol_flags), 64'h20);
    check_first("cd_first", 1'b1, 3'd1, 2'd1);
    tick();
    clear = 1'b0;
    check("cd_clr_flags", 64'(viol_flags), 64'h0);
    check("cd_clr_any",   64'(viol_any),   64'h0);
    check_first("cd_clr_first", 1'b0, 3'd0, 2'd0);

    // Reset in the middle of a wait: no DROP afterwards
    ch_req[0] = 1'b1;
    tick();
    g_resetn = 1'b0;
    tick();
    ch_req[0] = 1'b0;
    tick();
    g_resetn = 1'b1;
    tick();
    check("rw_flags", 64'(viol_flags), 64'h0);
    check("rw_txn",   64'(txn_count),  64'h0);
    tick();
    check("rw_nodrop", 64'(viol_flags),  64'h0);
    check("rw_first",  64'(first_valid), 64'h0);

    // Strobe changes ignored on a held read, flagged on a held write
    ch_wen[0] = 1'b0; ch_strb[3:0] = 4'h0; ch_req[0] = 1'b1;
    tick();
    ch_strb[3:0] = 4'hF;
    tick();
    check("rd_strb", 64'(viol_flags), 64'h0);
    ch_gnt[0] = 1'b1;
    tick();
    check("rd_txn0", 64'(txn_count[15:0]), 64'd1);
    ch_req[0] = 1'b0; ch_gnt[0] = 1'b0; ch_wen[0] = 1'b1; ch_strb[3:0] = 4'h0;
    tick();
    ch_req[0] = 1'b1;
    tick();
    ch_strb[3:0] = 4'hF;
    tick();
    check("wr_strb", 64'(viol_flags), 64'h01);
    check_first("wr_first", 1'b1, 3'd0, 2'd0);
    ch_req[0] = 1'b0; ch_wen[0] = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
